serpent_lt_pipe: RTL

Parametrised, pipelined Serpent linear transform (LT) engine with valid/ready flow control. It processes `LANES` independent 128-bit blocks per beat and applies the forward LT, or the inverse LT per beat when compiled in. It sits between the S-box layer and the key-mixing stage of the round datapath. It succeeds the combinational single-block LT with registered stages, backpressure and a mode bit that travels with the data.

---
 rtl/serpent_lt_pipe.sv | 112 +++++++++++
 1 files changed

// File: rtl/serpent_lt_pipe.sv
// serpent_lt_pipe: pipelined Serpent linear transform over LANES 128-bit blocks with valid/ready flow control
// Ports: i_clk/i_rst_n (async active-low reset); i_valid/o_ready/i_inv/i_data input beat;
// o_valid/i_ready/o_data output beat; o_busy = any stage holds a beat.
// Optional: define SERPENT_LT_INV_EN to build the per-beat inverse transform selected by i_inv.
module serpent_lt_pipe #(
  parameter int LANES = 1,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_inv,
  input  logic [128*LANES-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [128*LANES-1:0] o_data,
  output logic                 o_busy
);
  localparam int W = 128 * LANES;
  localparam int STEPS = 5;
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [127:0] lt_step(input logic [127:0] b, input int k, input logic inv);
    logic [31:0] x0, x1, x2, x3;
    {x3, x2, x1, x0} = b;
    if (!inv) begin
      case (k)
        0: begin x0 = rol(x0, 13); x2 = rol(x2, 3); end
        1: begin x1 = x1 ^ x0 ^ x2; x3 = x3 ^ x2 ^ (x0 << 3); end
        2: begin x1 = rol(x1, 1); x3 = rol(x3, 7); end
        3: begin x0 = x0 ^ x1 ^ x3; x2 = x2 ^ x3 ^ (x1 << 7); end
        default: begin x0 = rol(x0, 5); x2 = rol(x2, 22); end
      endcase
    end else begin
      case (k)
        0: begin x2 = rol(x2, 10); x0 = rol(x0, 27); end
        1: begin x2 = x2 ^ x3 ^ (x1 << 7); x0 = x0 ^ x1 ^ x3; end
        2: begin x3 = rol(x3, 25); x1 = rol(x1, 31); end
        3: begin x3 = x3 ^ x2 ^ (x0 << 3); x1 = x1 ^ x0 ^ x2; end
        default: begin x2 = rol(x2, 29); x0 = rol(x0, 19); end
      endcase
    end
    return {x3, x2, x1, x0};
  endfunction
  function automatic logic [W-1:0] stage_f(input logic [W-1:0] x, input int lo, input int hi, input logic inv);
    logic [127:0] b;
    logic [W-1:0] y;
    y = x;
    for (int l = 0; l < LANES; l++) begin
      b = x[128*l +: 128];
      for (int k = 0; k < STEPS; k++)
        if (k >= lo && k < hi) b = lt_step(b, k, inv);
      y[128*l +: 128] = b;
    end
    return y;
  endfunction
  logic [PIPE_DEPTH-1:0] v, adv;
  logic [W-1:0] dq [PIPE_DEPTH];
`ifndef SERPENT_LT_INV_EN
  logic unused_inv;
  assign unused_inv = i_inv;
`endif
  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
    // Steps [LO,HI) of the five-step sequence, spread evenly over the stages.
    localparam int LO = g * STEPS / PIPE_DEPTH;
    localparam int HI = (g + 1) * STEPS / PIPE_DEPTH;
    logic vin, iin, sv;
    logic [W-1:0] din, sd;
    if (g == 0) begin : g_head
      assign vin = i_valid;
      assign din = i_data;
`ifdef SERPENT_LT_INV_EN
      assign iin = i_inv;
`endif
    end else begin : g_body
      assign vin = v[g-1];
      assign din = dq[g-1];
`ifdef SERPENT_LT_INV_EN
      assign iin = g_stage[g-1].g_inv.si;
`endif
    end
`ifdef SERPENT_LT_INV_EN
    // The last stage's mode bit has no consumer, so it is only kept where a later stage reads it.
    if (g < PIPE_DEPTH - 1) begin : g_inv
      logic si;
      always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) si <= 1'b0;
        else if (adv[g] && vin) si <= iin;
    end
`else
    assign iin = 1'b0;
`endif
    // A stage may move when any stage from here to the output is empty or the output is taken.
    assign adv[g] = i_ready | ~(&v[PIPE_DEPTH-1:g]);
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        sv <= 1'b0;
        sd <= '0;
      end else if (adv[g]) begin
        sv <= vin;
        if (vin) sd <= stage_f(din, LO, HI, iin);
      end
    assign v[g] = sv;
    assign dq[g] = sd;
  end
  assign o_ready = adv[0];
  assign o_valid = v[PIPE_DEPTH-1];
  assign o_data = dq[PIPE_DEPTH-1];
  assign o_busy = |v;
endmodule
